mem_io_responder: RTL and testbench

Memory-and-I/O responder at the far end of the CPU byte bus: consumes `mem_a`/`mem_wr`/`mem_dout` and returns `mem_din` and `io_buffer_full`.

- Holds the 128 KB byte RAM, answering reads one cycle later.
- Decodes the I/O window at `mem_a[17:16]==2'b11` into UART TX/RX and a cycle counter.
- Runs the program-stop sequence.
- Sits beside `cpu` in the top-level harness, replacing the behavioural RAM/UART glue.

---
 rtl/mem_io_responder_if.sv | 26 ++
 rtl/mem_io_responder.sv | 133 +++++++++++++
 tb/tb_mem_io_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU byte bus, UART TX/RX and status signals between the harness and mem_io_responder.
// master = harness/CPU side, slave = responder side.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_pop;
    logic        halted;

    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_empty,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, halted
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_empty,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, halted
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM, UART/cycle-counter I/O window at mem_a[17:16]==2'b11, and the program-stop sequencer.
// Define MEM_IO_STATUS_EN to add a sticky TX overflow flag readable at 0x30008.
module mem_io_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH   = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    mem_io_responder_if.slave  bus
);
    localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SEND_NUL, ST_HALTED} state_e;

    state_e           state_q;
    logic [7:0]       ram [RAM_WORDS];
    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [31:0]      cycle_cnt_q, snap_q;
    logic [7:0]       mem_din_q, rdata;

    logic             is_io, rd_req, wr_req, tx_wr, push, pop, full, tx_valid_c;
    logic [15:0]      io_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic             unused_addr;

    assign is_io       = (bus.mem_a[17:16] == 2'b11);
    assign io_off      = bus.mem_a[15:0];
    assign ram_idx     = bus.mem_a[ADDR_WIDTH-1:0];
    assign unused_addr = ^bus.mem_a[31:18];

    // Halted blocks every CPU write; reads keep responding.
    assign rd_req = rdy_in && !bus.mem_wr;
    assign wr_req = rdy_in && bus.mem_wr && (state_q != ST_HALTED);

    assign full       = (fifo_cnt_q == CNT_W'(TX_DEPTH));
    assign tx_valid_c = (state_q == ST_SEND_NUL) ||
                        (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (fifo_cnt_q != '0));
    assign pop        = tx_valid_c && bus.tx_ready && (state_q != ST_SEND_NUL);
    assign tx_wr      = wr_req && is_io && (io_off == 16'h0000) && (bus.mem_dout != 8'h00);
    assign push       = tx_wr && (state_q == ST_RUN) && (!full || pop);

    assign bus.tx_valid       = tx_valid_c;
    assign bus.tx_data        = (state_q == ST_RUN || state_q == ST_DRAIN) && (fifo_cnt_q != '0)
                                ? fifo_mem[rd_ptr_q] : 8'h00;
    assign bus.io_buffer_full = (fifo_cnt_q >= CNT_W'(TX_DEPTH - 2));
    assign bus.rx_pop         = rd_req && is_io && (io_off == 16'h0000) && !bus.rx_empty;
    assign bus.halted         = (state_q == ST_HALTED);
    assign bus.mem_din        = mem_din_q;

`ifdef MEM_IO_STATUS_EN
    logic tx_overflow_q;
    logic drop;
    assign drop = tx_wr && !push;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)   tx_overflow_q <= 1'b0;
        else if (drop) tx_overflow_q <= 1'b1;
    end
`endif

    // Read mux; 0x30004 returns the live count byte 0, 0x30005..7 the snapshot.
    always_comb begin
        rdata = 8'h00;
        if (!is_io) begin
            rdata = ram[ram_idx];
        end else begin
            case (io_off)
                16'h0000: rdata = bus.rx_empty ? 8'h00 : bus.rx_data;
                16'h0004: rdata = cycle_cnt_q[7:0];
                16'h0005: rdata = snap_q[15:8];
                16'h0006: rdata = snap_q[23:16];
                16'h0007: rdata = snap_q[31:24];
`ifdef MEM_IO_STATUS_EN
                16'h0008: rdata = {6'b0, bus.halted, tx_overflow_q};
`endif
                default:  rdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Storage arrays carry no reset.
    always_ff @(posedge clk_in) begin
        if (wr_req && !is_io) ram[ram_idx] <= bus.mem_dout;
        if (push)             fifo_mem[wr_ptr_q] <= bus.mem_dout;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            cycle_cnt_q <= 32'h0;
            snap_q      <= 32'h0;
            mem_din_q   <= 8'h00;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (rdy_in && (state_q != ST_HALTED)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (rd_req && is_io && (io_off == 16'h0004)) snap_q <= cycle_cnt_q;
            if (rd_req) mem_din_q <= rdata;
        end
    end

    // Stop sequencer: drain the FIFO, send the NUL terminator, then halt until reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:      if (wr_req && is_io && (io_off == 16'h0004)) state_q <= ST_DRAIN;
                ST_DRAIN:    if (fifo_cnt_q == '0) state_q <= ST_SEND_NUL;
                ST_SEND_NUL: if (bus.tx_ready) state_q <= ST_HALTED;
                ST_HALTED:   state_q <= ST_HALTED;
                default:     state_q <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: vector table plus read/TX scoreboards.
module tb_mem_io_responder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;

    mem_io_responder_if bus();

    mem_io_responder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

`ifdef MEM_IO_STATUS_EN
    localparam logic [7:0] STAT_OVF  = 8'h01;
    localparam logic [7:0] STAT_HALT = 8'h03;
`else
    localparam logic [7:0] STAT_OVF  = 8'h00;
    localparam logic [7:0] STAT_HALT = 8'h00;
`endif

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cyc_m   = 32'h0;
    logic        m_halted = 1'b0;
    logic [7:0]  txq[$];
    logic [7:0]  rdq[$];
    vec_t        vecs[11];
    logic [31:0] snap_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: TX monitor and counter model sample at the falling edge, then the rising edge passes.
    task automatic tick();
        logic       nul;
        logic [7:0] e;
        nul = 1'b0;
        @(negedge clk_in);
        if (rst_in) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (txq.size() == 0) begin
                    chk("tx_unexpected", 32'(bus.tx_data), 32'h100);
                end else begin
                    e = txq.pop_front();
                    chk("tx_byte", 32'(bus.tx_data), 32'(e));
                    nul = (e == 8'h00);
                end
            end
            if (rdy_in && !m_halted) cyc_m = cyc_m + 32'd1;
            if (nul) m_halted = 1'b1;
        end
        @(posedge clk_in);
        #1;
    endtask

    // Idle bus: a write to an unmapped I/O address, which leaves mem_din alone.
    task automatic park();
        bus.mem_a    = 32'h0003_000C;
        bus.mem_wr   = 1'b1;
        bus.mem_dout = 8'h00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a = a; bus.mem_wr = 1'b1; bus.mem_dout = d; rdy_in = 1'b1;
        tick();
        park();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string name);
        rdq.push_back(exp);
        bus.mem_a = a; bus.mem_wr = 1'b0; rdy_in = 1'b1;
        tick();
        park();
        chk(name, 32'(bus.mem_din), 32'(rdq.pop_front()));
    endtask

    task automatic txw(input logic [7:0] d, input bit accept);
        if (accept) txq.push_back(d);
        wr(32'h0003_0000, d);
    endtask

    task automatic drain(input string name, input bit expect_idle);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (txq.size() == 0) break;
            tick();
        end
        chk({name, "_timeout"}, 32'(txq.size()), 32'd0);
        if (expect_idle) chk({name, "_idle"}, 32'(bus.tx_valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_din"},  32'(bus.mem_din), 32'h0);
        chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'h0);
        chk({tag, "_tx_data"},  32'(bus.tx_data), 32'h0);
        chk({tag, "_rx_pop"},   32'(bus.rx_pop), 32'h0);
        chk({tag, "_ibf"},      32'(bus.io_buffer_full), 32'h0);
        chk({tag, "_halted"},   32'(bus.halted), 32'h0);
    endtask

    initial begin
        park();
        bus.tx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_empty = 1'b1;

        vecs[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 8'h00};
        vecs[1]  = '{32'h0000_0010, 1'b0, 8'h00, 8'hA5};
        vecs[2]  = '{32'h0002_0010, 1'b0, 8'h00, 8'hA5};
        vecs[3]  = '{32'h0001_FFFF, 1'b1, 8'h5A, 8'h00};
        vecs[4]  = '{32'h0001_FFFF, 1'b0, 8'h00, 8'h5A};
        vecs[5]  = '{32'h0000_0011, 1'b1, 8'hC3, 8'h00};
        vecs[6]  = '{32'h0000_0011, 1'b0, 8'h00, 8'hC3};
        vecs[7]  = '{32'h0000_0010, 1'b0, 8'h00, 8'hA5};
        vecs[8]  = '{32'h0003_0010, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{32'h0003_0000, 1'b0, 8'h00, 8'h00};
        vecs[10] = '{32'h0003_0008, 1'b0, 8'h00, 8'h00};

        repeat (2) @(posedge clk_in);
        #1;
        chk_reset_outputs("por");
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) wr(vecs[i].a, vecs[i].d);
            else            rd(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // RX pop strobe and read data.
        bus.rx_empty = 1'b0; bus.rx_data = 8'h33;
        rdq.push_back(8'h33);
        bus.mem_a = 32'h0003_0000; bus.mem_wr = 1'b0; rdy_in = 1'b1;
        #1 chk("rx_pop_on", 32'(bus.rx_pop), 32'h1);
        tick();
        park();
        chk("rx_data", 32'(bus.mem_din), 32'(rdq.pop_front()));
        bus.mem_a = 32'h0003_0000; bus.mem_wr = 1'b0; rdy_in = 1'b0;
        #1 chk("rx_pop_rdy_low", 32'(bus.rx_pop), 32'h0);
        tick();
        chk("mem_din_hold", 32'(bus.mem_din), 32'h33);
        bus.mem_wr = 1'b1; rdy_in = 1'b1;
        #1 chk("rx_pop_write", 32'(bus.rx_pop), 32'h0);
        tick();
        park();
        bus.rx_empty = 1'b1;
        rd(32'h0003_0000, 8'h00, "rx_empty_read");

        // UART output: NUL ignored, order preserved.
        bus.tx_ready = 1'b0;
        txw(8'h41, 1'b1); txw(8'h00, 1'b0); txw(8'h42, 1'b1);
        chk("uart_valid", 32'(bus.tx_valid), 32'h1);
        chk("uart_head",  32'(bus.tx_data), 32'h41);
        drain("uart_drain", 1'b1);

        // Full threshold, drop on full, push accepted alongside pop when full.
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) txw(8'(i), 1'b1);
        chk("ibf_at5", 32'(bus.io_buffer_full), 32'h0);
        txw(8'h06, 1'b1);
        chk("ibf_at6", 32'(bus.io_buffer_full), 32'h1);
        txw(8'h07, 1'b1); txw(8'h08, 1'b1); txw(8'h09, 1'b0);
        chk("full_head", 32'(bus.tx_data), 32'h01);
        rd(32'h0003_0008, STAT_OVF, "status_ovf");
        bus.tx_ready = 1'b1;
        txw(8'h0A, 1'b1);
        drain("full_drain", 1'b1);

        // Counter coherence across a stall and across a byte boundary.
        rdy_in = 1'b0;
        repeat (5) tick();
        snap_m = cyc_m;
        rd(32'h0003_0004, snap_m[7:0], "cnt_b0");
        rd(32'h0003_0005, snap_m[15:8], "cnt_b1");
        rd(32'h0003_0006, snap_m[23:16], "cnt_b2");
        rd(32'h0003_0007, snap_m[31:24], "cnt_b3");
        rdy_in = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (cyc_m[7:0] == 8'hFF) break;
            tick();
        end
        snap_m = cyc_m;
        rd(32'h0003_0004, snap_m[7:0], "cnt_ff_b0");
        rd(32'h0003_0005, snap_m[15:8], "cnt_ff_b1");
        snap_m = cyc_m;
        rd(32'h0003_0004, snap_m[7:0], "cnt_wrap_b0");
        rd(32'h0003_0005, snap_m[15:8], "cnt_wrap_b1");

        // Reset during DRAIN discards FIFO and pending stop.
        bus.tx_ready = 1'b0;
        txw(8'h51, 1'b1); txw(8'h52, 1'b1);
        wr(32'h0003_0004, 8'h01);
        txw(8'h53, 1'b0);
        chk("drain_valid", 32'(bus.tx_valid), 32'h1);
        rdy_in = 1'b0;
        #2 rst_in = 1'b0;
        #1 chk_reset_outputs("midrst");
        txq.delete(); rdq.delete();
        cyc_m = 32'h0; m_halted = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        txw(8'h54, 1'b1);
        chk("post_rst_head", 32'(bus.tx_data), 32'h54);
        drain("post_rst_drain", 1'b1);

        // Stop sequence: 3 bytes then NUL, then halted and write-protected.
        bus.tx_ready = 1'b0;
        txw(8'h61, 1'b1); txw(8'h62, 1'b1); txw(8'h63, 1'b1);
        wr(32'h0003_0004, 8'h00);
        txw(8'h64, 1'b0);
        chk("pre_halt", 32'(bus.halted), 32'h0);
        txq.push_back(8'h00);
        drain("stop_drain", 1'b0);
        chk("halted", 32'(bus.halted), 32'h1);
        chk("halt_tx_valid", 32'(bus.tx_valid), 32'h0);
        wr(32'h0000_0010, 8'h77);
        rd(32'h0000_0010, 8'hA5, "halt_ram_protect");
        rd(32'h0003_0008, STAT_HALT, "status_halt");
        txw(8'h65, 1'b0);
        chk("halt_no_push", 32'(bus.tx_valid), 32'h0);
        rd(32'h0003_0004, cyc_m[7:0], "cnt_frozen_a");
        repeat (3) tick();
        rd(32'h0003_0004, cyc_m[7:0], "cnt_frozen_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
